// File: rtl/logic_arb_pkg.sv
// Shared types and constants for the two-requester bitwise-operation arbiter.
package logic_arb_pkg;

    localparam int CNT_W = 16;

    typedef logic [3:0] func_t;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/logic_arb_if.sv
// Request/response bundle between two requesters, the arbiter and the result consumer.
interface logic_arb_if #(parameter int WIDTH = 32);
    import logic_arb_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    func_t            req0_f;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    func_t            req1_f;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_id;
    logic [CNT_W-1:0] done_cnt;

    modport master (
        output req0_valid, req0_f, req0_a, req0_b,
        output req1_valid, req1_f, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_y, rsp_id, done_cnt
    );

    modport slave (
        input  req0_valid, req0_f, req0_a, req0_b,
        input  req1_valid, req1_f, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_y, rsp_id, done_cnt
    );

endinterface

// File: rtl/logic_arb_ae.sv
// Bitwise unit: F is a 2-input truth table applied per bit, indexed by {A[i], B[i]}.
module AE #(parameter int WIDTH = 32) (
    input  logic [3:0]       F,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y
);

    assign Y = ({WIDTH{F[3]}} &  A &  B)
             | ({WIDTH{F[2]}} &  A & ~B)
             | ({WIDTH{F[1]}} & ~A &  B)
             | ({WIDTH{F[0]}} & ~A & ~B);

endmodule

// File: rtl/logic_arb.sv
// Alternating-priority arbiter feeding one shared AE unit into a single result register.
module logic_arb #(parameter int WIDTH = 32) (
    input  logic         clk,
    input  logic         rst_n,
    logic_arb_if.slave   bus
);
    import logic_arb_pkg::*;

    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_y;
    req_id_t          r_rsp_id;
    req_id_t          r_prio;
    logic [CNT_W-1:0] r_done_cnt;

    logic             w_can_accept;
    logic             w_gnt_valid;
    req_id_t          w_gnt_id;
    logic             w_accept;
    func_t            w_f;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_y;

    logic             w_nxt_valid;
    logic [WIDTH-1:0] w_nxt_y;
    req_id_t          w_nxt_id;
    req_id_t          w_nxt_prio;
    logic [CNT_W-1:0] w_nxt_cnt;

    assign w_can_accept = !r_rsp_valid || bus.rsp_ready;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = REQ0;
        if (r_prio == REQ0) begin
            if (bus.req0_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = REQ0;
            end else if (bus.req1_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = REQ1;
            end
        end else begin
            if (bus.req1_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = REQ1;
            end else if (bus.req0_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = REQ0;
            end
        end
    end

    // Readies are gated by rst_n so nothing is offered while reset is held.
    assign w_accept       = rst_n && w_can_accept && w_gnt_valid;
    assign bus.req0_ready = w_accept && (w_gnt_id == REQ0);
    assign bus.req1_ready = w_accept && (w_gnt_id == REQ1);

    assign w_f = (w_gnt_id == REQ1) ? bus.req1_f : bus.req0_f;
    assign w_a = (w_gnt_id == REQ1) ? bus.req1_a : bus.req0_a;
    assign w_b = (w_gnt_id == REQ1) ? bus.req1_b : bus.req0_b;

    AE #(.WIDTH(WIDTH)) u_ae (
        .F (w_f),
        .A (w_a),
        .B (w_b),
        .Y (w_y)
    );

    always_comb begin
        w_nxt_valid = r_rsp_valid;
        w_nxt_y     = r_rsp_y;
        w_nxt_id    = r_rsp_id;
        w_nxt_prio  = r_prio;
        w_nxt_cnt   = r_done_cnt;
        if (r_rsp_valid && bus.rsp_ready)
            w_nxt_cnt = r_done_cnt + 1'b1;
        if (w_accept) begin
            w_nxt_valid = 1'b1;
            w_nxt_y     = w_y;
            w_nxt_id    = w_gnt_id;
            w_nxt_prio  = (w_gnt_id == REQ0) ? REQ1 : REQ0;
        end else if (bus.rsp_ready) begin
            w_nxt_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_id    <= REQ0;
            r_prio      <= REQ0;
            r_done_cnt  <= '0;
        end else begin
            r_rsp_valid <= w_nxt_valid;
            r_rsp_y     <= w_nxt_y;
            r_rsp_id    <= w_nxt_id;
            r_prio      <= w_nxt_prio;
            r_done_cnt  <= w_nxt_cnt;
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_y     = r_rsp_y;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_logic_arb.sv
// Randomized and directed checks of logic_arb against a behavioural reference model.
module tb_logic_arb;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic_arb_if #(.WIDTH(W)) bus ();

    logic_arb #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what the result register should hold, plus priority and delivery count.
    bit          m_valid;
    logic [W-1:0] m_y;
    int          m_id;
    int          m_prio;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Truth-table lookup per bit: output bit = F[{a_bit, b_bit}].
    function automatic logic [W-1:0] ae_ref(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] y;
        for (int i = 0; i < W; i++) begin
            int idx;
            idx  = 2 * int'(a[i]) + int'(b[i]);
            y[i] = f[idx];
        end
        return y;
    endfunction

    // Drive one cycle's inputs, check outputs against the model, clock, then advance the model.
    task automatic step(input bit rstn, input bit v0, input bit v1,
                        input logic [3:0] f0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [3:0] f1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input bit rr);
        int  win;
        bit  acc;
        rst_n          = rstn;
        bus.req0_valid = v0; bus.req0_f = f0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_f = f1; bus.req1_a = a1; bus.req1_b = b1;
        bus.rsp_ready  = rr;
        #1;
        if (m_prio == 0) win = v0 ? 0 : (v1 ? 1 : -1);
        else             win = v1 ? 1 : (v0 ? 0 : -1);
        acc = rstn && (!m_valid || rr) && (win >= 0);
        check("req0_ready", 32'(bus.req0_ready), 32'(acc && win == 0));
        check("req1_ready", 32'(bus.req1_ready), 32'(acc && win == 1));
        check("rsp_valid",  32'(bus.rsp_valid),  32'(m_valid));
        check("rsp_y",      bus.rsp_y,           m_y);
        check("rsp_id",     32'(bus.rsp_id),     32'(m_id));
        check("done_cnt",   32'(bus.done_cnt),   32'(m_cnt));
        @(posedge clk);
        if (!rstn) begin
            m_valid = 0; m_y = '0; m_id = 0; m_prio = 0; m_cnt = 0;
        end else begin
            if (m_valid && rr) m_cnt = (m_cnt + 1) % 65536;
            if (acc) begin
                m_y     = (win == 0) ? ae_ref(f0, a0, b0) : ae_ref(f1, a1, b1);
                m_id    = win;
                m_valid = 1;
                m_prio  = 1 - win;
            end else if (rr) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rstn, input bit rr);
        step(rstn, 0, 0, 4'h0, '0, '0, 4'h0, '0, '0, rr);
    endtask

    task automatic rnd_step(input bit v0, input bit v1, input bit rr);
        step(1, v0, v1, 4'($urandom), W'($urandom), W'($urandom),
             4'($urandom), W'($urandom), W'($urandom), rr);
    endtask

    initial begin
        m_valid = 0; m_y = '0; m_id = 0; m_prio = 0; m_cnt = 0;
        rst_n = 1'b0;
        bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 0;
        bus.req0_f = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_f = '0; bus.req1_a = '0; bus.req1_b = '0;
        @(negedge clk);

        // Reset with requests pending: readies must stay low.
        step(0, 1, 1, 4'h6, '1, '0, 4'h8, '1, '1, 1);
        idle(0, 0);

        // Single op from req0, a=FFFF0000 b=0F0F0F0F, XOR table.
        step(1, 1, 0, 4'h6, 32'hFFFF0000, 32'h0F0F0F0F, 4'h0, '0, '0, 1);
        check("first_y_xor", bus.rsp_y, 32'hF0F00F0F);
        idle(1, 1);
        check("first_cnt", 32'(bus.done_cnt), 32'd1);

        // Both valid, alternating grants starting with 0 after reset.
        idle(0, 1);
        for (int k = 0; k < 6; k++) begin
            rnd_step(1, 1, 1);
            check("alt_id", 32'(bus.rsp_id), 32'(k % 2));
        end

        // Back-pressure: frozen result, both readies low, then drain with same-edge accept.
        for (int k = 0; k < 3; k++) rnd_step(1, 1, 0);
        rnd_step(1, 1, 1);
        idle(1, 1);

        // Only req1 valid: granted every cycle, priority returns to 0.
        idle(0, 1);
        for (int k = 0; k < 4; k++) begin
            rnd_step(0, 1, 1);
            check("req1_only_id", 32'(bus.rsp_id), 32'd1);
            check("req1_only_prio", 32'(m_prio), 32'd0);
        end
        idle(1, 1);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 49) == 0) idle(0, 1'($urandom));
            else rnd_step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 3) != 0));
        end

        // Reset while a result is stalled: discarded, not counted, nothing delivered afterwards.
        rnd_step(1, 0, 1);
        rnd_step(1, 0, 0);
        idle(0, 0);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_cnt", 32'(bus.done_cnt), 32'd0);
        idle(1, 1);
        idle(1, 1);
        check("rst_no_spurious", 32'(bus.done_cnt), 32'd0);

        // done_cnt wrap: 65536 back-to-back accepts then one drain.
        for (int k = 0; k < 65536; k++) rnd_step(1, 0, 1);
        check("pre_wrap", 32'(bus.done_cnt), 32'h0000FFFF);
        idle(1, 1);
        check("wrap", 32'(bus.done_cnt), 32'h00000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
